// File: rtl/video_pkg.sv
// video_pkg: shared definitions for the video line path.
//   - ld_state_t : line loader sequencer states
//   - PIXELS_DEF / ACTIVE_LINES_DEF : raster geometry shared with the timer
//   - ADDR_W_DEF : frame-memory address width
package video_pkg;
  localparam int PIXELS_DEF       = 320;
  localparam int ACTIVE_LINES_DEF = 240;
  localparam int ADDR_W_DEF       = 17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FETCH,
    S_DRAIN
  } ld_state_t;
endpackage

// File: rtl/skid2.sv
// skid2: 2-entry FIFO catching frame-memory read data in flight.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   push / din   : enqueue din
//   pop          : dequeue head (ignored when nothing is valid)
//   flush        : drop all entries
//   count        : entries held in storage
//   valid / head : head available; when storage is empty the incoming
//                  push data falls through so a byte can leave the same
//                  cycle it arrives
module skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic         valid,
  output logic [W-1:0] head
);
  logic [W-1:0] mem [2];
  logic         rd_ptr, wr_ptr;
  logic         store, take;

  // Pushing and popping an empty FIFO passes data straight through.
  assign take  = pop && (count != 2'd0);
  assign store = push && !(pop && (count == 2'd0));
  assign valid = (count != 2'd0) || push;
  assign head  = (count != 2'd0) ? mem[rd_ptr] : din;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (take) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, store} - {1'b0, take};
    end
  end
endmodule

// File: rtl/line_loader.sv
// line_loader: fills the video generator's line buffer one raster line
// ahead of display. On each change of the displayed line it reads PIXELS
// bytes of the next row from a 1-cycle-latency frame memory and pushes
// them through the write/ready handshake.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   enable             : allows new loads to start
//   line               : current displayed line
//   base_next          : frame base, latched at frame start (line -> 0)
//   ready / write      : line buffer handshake, data_o is the byte
//   mem_rd / mem_addr  : frame-memory read strobe and address
//   mem_data           : read data, one cycle after mem_rd
//   busy               : load in progress
//   overrun / clr_overrun : sticky aborted-load flag and its clear
module line_loader
  import video_pkg::*;
#(
  parameter int PIXELS       = PIXELS_DEF,
  parameter int ACTIVE_LINES = ACTIVE_LINES_DEF,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [7:0]        line,
  input  logic [ADDR_W-1:0] base_next,
  input  logic              ready,
  output logic              write,
  output logic [7:0]        data_o,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_overrun
);
  localparam int COL_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIXELS - 1);

  ld_state_t         state;
  logic [7:0]        line_q, row_q, tgt_row;
  logic [8:0]        line_inc;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] base_cur, row_off;
  logic              rd_pend;
  logic              line_chg, tgt_active, start, abort;
  logic [1:0]        sk_count;
  logic              sk_valid;
  logic [7:0]        sk_head;
  logic [2:0]        inflight;

  assign line_chg   = (line != line_q);
  assign line_inc   = {1'b0, line} + 9'd1;
  // Past the last active line only line 255 wraps to row 0 (next frame).
  assign tgt_active = (line == 8'hFF) || (line_inc < 9'(ACTIVE_LINES));
  assign tgt_row    = (line == 8'hFF) ? 8'd0 : line_inc[7:0];
  assign start      = line_chg && enable && tgt_active;
  assign abort      = line_chg && (state != S_IDLE);

  // Bytes stored plus reads in flight may never exceed the skid depth.
  // No read is issued in the abort cycle so nothing stale is in flight.
  assign inflight = {1'b0, sk_count} + {2'b00, rd_pend};
  assign mem_rd   = (state == S_FETCH) && ready && !line_chg && (inflight < 3'd2);
  // The abort cycle emits nothing: the skid holds the old line's data.
  assign write    = ready && sk_valid && !abort;
  assign data_o   = sk_valid ? sk_head : 8'd0;
  assign busy     = (state != S_IDLE);

  generate
    if (PIXELS == 320) begin : g_row_shift
      logic [16:0] prod;
      assign prod    = {1'b0, row_q, 8'b0} + {3'b0, row_q, 6'b0};
      assign row_off = ADDR_W'(prod);
    end else begin : g_row_mul
      assign row_off = ADDR_W'(32'(row_q) * 32'(PIXELS));
    end
  endgenerate

  assign mem_addr = base_cur + row_off + ADDR_W'(col);

  skid2 #(.W(8)) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (rd_pend),
    .pop   (write),
    .flush (abort),
    .din   (mem_data),
    .count (sk_count),
    .valid (sk_valid),
    .head  (sk_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      line_q   <= 8'd0;
      row_q    <= 8'd0;
      col      <= '0;
      base_cur <= '0;
      rd_pend  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      line_q  <= line;
      rd_pend <= mem_rd;
      if (line_chg && (line == 8'd0)) base_cur <= base_next;
      if (abort)            overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;

      if (line_chg) begin
        // A line change either starts a load or (when aborting into a
        // blank/disabled line) leaves the loader idle.
        if (start) begin
          state <= S_WAIT;
          row_q <= tgt_row;
          col   <= '0;
        end else begin
          state <= S_IDLE;
        end
      end else begin
        case (state)
          S_WAIT:  if (ready) state <= S_FETCH;
          S_FETCH: if (mem_rd) begin
            col <= col + 1'b1;
            if (col == COL_LAST) state <= S_DRAIN;
          end
          S_DRAIN: if ((sk_count == 2'd0) && !rd_pend) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_line_loader.sv
module tb_line_loader;
  localparam int PIX = 8;
  localparam int ACT = 4;
  localparam int AW  = 17;

  logic          clk = 1'b0;
  logic          reset, enable, ready, clr_overrun;
  logic          write, mem_rd, busy, overrun;
  logic [7:0]    line, data_o, mem_data;
  logic [AW-1:0] base_next, mem_addr;

  line_loader #(.PIXELS(PIX), .ACTIVE_LINES(ACT), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .line(line),
    .base_next(base_next), .ready(ready), .write(write), .data_o(data_o),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Frame memory: mem[a] = a[7:0], one cycle latency, junk otherwise.
  always @(posedge clk) mem_data <= mem_rd ? mem_addr[7:0] : 8'($urandom);

  int n_vec = 0, n_bad = 0, n_writes = 0, last_wr = 0;
  bit wrote_load = 0;
  logic [7:0]    exp_q[$];
  logic [AW-1:0] addr_q[$];

  task automatic chk(string nm, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm, string msg);
    n_vec++;
    n_bad++;
    $display("FAIL %s: %s", nm, msg);
  endtask

  // Monitor: pops the scoreboard on every write / read strobe.
  always @(negedge clk) if (!reset) begin
    if (write) begin
      chk("write_needs_ready", ready, 1);
      if (exp_q.size() == 0) fail("unexpected_write", $sformatf("got byte 0x%0h, expected no write", data_o));
      else chk("data_o", data_o, exp_q.pop_front());
      n_writes++;
      last_wr    = cyc;
      wrote_load = 1;
    end else if (ready && wrote_load && exp_q.size() != 0) begin
      fail("write_gap", "got no write with ready=1 mid-line, expected a write");
    end
    if (mem_rd) begin
      if (addr_q.size() == 0) fail("unexpected_mem_rd", $sformatf("got read of 0x%0h, expected none", mem_addr));
      else chk("mem_addr", mem_addr, addr_q.pop_front());
    end
  end

  // ready pattern: 0 = always high, 1 = toggle, 2 = random
  int rmode = 0;
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = ~ready;
        default: ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model: line number -> row -> list of addresses and bytes.
  int            line_m = 0;
  logic [AW-1:0] base_m = '0;

  task automatic set_line(int v);
    int row;
    logic [AW-1:0] a;
    exp_q.delete();
    addr_q.delete();
    wrote_load = 0;
    if (v == 0) base_m = base_next;
    if (v == 255)         row = 0;
    else if (v + 1 < ACT) row = v + 1;
    else                  row = -1;
    if (enable && row >= 0)
      for (int k = 0; k < PIX; k++) begin
        a = AW'(base_m + row * PIX + k);
        addr_q.push_back(a);
        exp_q.push_back(a[7:0]);
      end
    line   = 8'(v);
    line_m = v;
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(string nm);
    int t = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0) && t < 300) begin tick(); t++; end
    if (t >= 300) fail(nm, $sformatf("got %0d bytes still pending, expected 0", exp_q.size()));
    tick(3);
    chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic wait_rd(string nm, output int c);
    int t = 0;
    c = 0;
    while (t < 50) begin
      @(negedge clk);
      if (mem_rd) break;
      t++;
    end
    if (t >= 50) fail(nm, "got no mem_rd, expected a read");
    c = cyc;
  endtask

  task automatic wait_writes(int n);
    int t = 0;
    while (n_writes < n && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail("wait_writes", $sformatf("got %0d writes, expected %0d", n_writes, n));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int drv, t_rd, n0, v;
    int vals[7] = '{0, 1, 2, 3, 4, 7, 255};
    reset = 1; enable = 1; line = 0; base_next = '0; clr_overrun = 0;
    tick(2);
    @(negedge clk);
    chk("rst_write", write, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_data_o", data_o, 0);
    @(posedge clk); #1;
    reset = 0;

    // Basic load: 255 -> row 0 (old base), 0 -> frame start, row 1.
    base_next = 17'h100;
    set_line(255);
    drv = cyc;
    wait_rd("row0_rd", t_rd);
    chk("start_latency", t_rd - drv, 2);
    wait_idle("row0");
    set_line(0);
    wait_rd("row1_rd", t_rd);
    wait_idle("row1");
    chk("line_cycles", last_wr - t_rd, PIX);

    // Blanking: lines 3 and 4 have no active target.
    set_line(3);
    repeat (6) begin @(negedge clk); chk("blank3_busy", busy, 0); end
    tick();
    set_line(4);
    repeat (6) begin @(negedge clk); chk("blank4_busy", busy, 0); end
    tick();

    // Overrun: abort row 2 after 3 bytes, row 3 then loads completely.
    chk("overrun_pre", overrun, 0);
    n0 = n_writes;
    set_line(1);
    wait_writes(n0 + 3);
    tick();
    set_line(2);
    wait_idle("row3_after_abort");
    chk("overrun_set", overrun, 1);
    clr_overrun = 1;
    tick();
    clr_overrun = 0;
    @(negedge clk);
    chk("overrun_clr", overrun, 0);
    tick();

    // Backpressure: ready toggles every cycle.
    rmode = 1;
    set_line(0);
    wait_idle("backpressure");
    rmode = 0;
    tick();

    // Disable: no start while low; dropping it mid-fetch keeps the load.
    enable = 0;
    set_line(1);
    repeat (8) begin @(negedge clk); chk("disabled_busy", busy, 0); end
    tick();
    enable = 1;
    set_line(2);
    wait_rd("dis_rd", t_rd);
    tick();
    enable = 0;
    wait_idle("disable_mid");
    enable = 1;
    chk("disable_overrun", overrun, 0);

    // Mid-load reset.
    set_line(1);
    wait_rd("rst_rd", t_rd);
    tick(2);
    reset = 1;
    line = 0; line_m = 0; base_m = '0;
    exp_q.delete(); addr_q.delete(); wrote_load = 0;
    tick();
    reset = 0;
    @(negedge clk);
    chk("midrst_write", write, 0);
    chk("midrst_mem_rd", mem_rd, 0);
    chk("midrst_busy", busy, 0);
    tick();
    set_line(2);
    wait_idle("post_reset");

    // Randomized loads with random base and ready patterns.
    for (int i = 0; i < 25; i++) begin
      base_next = AW'($urandom);
      rmode = int'($urandom_range(0, 2));
      do v = vals[$urandom_range(0, 6)]; while (v == line_m);
      set_line(v);
      wait_idle("rand");
    end
    chk("rand_overrun", overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
